fpu_op_scheduler: RTL and testbench

- Shares one combinational FPU instance (16-bit add path rs1/rs2->rd1, mult path rs3/rs4->rd2, inst mode pin) between two requesters, e.g. the core FP issue port and a DMA/accelerator port.
- Per-unit round-robin arbitration; one add and one mult can issue in the same cycle.
- Captures FPU results into per-requester registered response slots with valid/ready handshake.
- Keeps saturating issue counters for performance monitoring.

---
 rtl/fpu_sched_pkg.sv | 20 ++
 rtl/fpu_op_scheduler_rr_arb2.sv | 37 +++
 rtl/fpu_op_scheduler.sv | 153 +++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fpu_sched_pkg                                                      |
// | Brief  : Op encodings and bfloat16 constants shared by the FPU scheduler.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
package fpu_sched_pkg;

  localparam int NUM_REQ = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [15:0] BF16_ONE   = 16'h3F80;
  localparam logic [15:0] BF16_TWO   = 16'h4000;
  localparam logic [15:0] BF16_THREE = 16'h4040;
  localparam logic [15:0] BF16_SIX   = 16'h40C0;

endpackage
`default_nettype wire

// File: rtl/fpu_op_scheduler_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arb2                                                            |
// | Brief  : Two-way round-robin arbiter; pointer names the favoured requester. |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_ptr;
  logic [1:0] w_gnt;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    w_gnt    = 2'b00;
    w_gnt[0] = req[0] & (~req[1] | ~r_ptr);
    w_gnt[1] = req[1] & (~req[0] |  r_ptr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (w_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

  assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/fpu_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fpu_op_scheduler                                                   |
// | Brief  : Shares one add/mult FPU between two requesters, one-deep responses.|
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int   W        = 16,
  parameter int   TAG_W    = 4,
  parameter int   CNT_W    = 16,
  parameter logic FPU_INST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*W-1:0]       req_a,
  input  logic [NUM_REQ*W-1:0]       req_b,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ*W-1:0]       rsp_data,
  output logic [NUM_REQ*TAG_W-1:0]   rsp_tag,
  output logic [NUM_REQ-1:0]         rsp_op,
  output logic                       fpu_inst,
  output logic [W-1:0]               fpu_rs1,
  output logic [W-1:0]               fpu_rs2,
  output logic [W-1:0]               fpu_rs3,
  output logic [W-1:0]               fpu_rs4,
  input  logic [W-1:0]               fpu_rd1,
  input  logic [W-1:0]               fpu_rd2,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           add_cnt,
  output logic [CNT_W-1:0]           mul_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_slot_free;
  logic [NUM_REQ-1:0] w_elig_add;
  logic [NUM_REQ-1:0] w_elig_mul;
  logic [NUM_REQ-1:0] w_gnt_add;
  logic [NUM_REQ-1:0] w_gnt_mul;
  logic [NUM_REQ-1:0] w_gnt;

  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [W-1:0]       r_rsp_data [NUM_REQ];
  logic [TAG_W-1:0]   r_rsp_tag  [NUM_REQ];
  logic [NUM_REQ-1:0] r_rsp_op;
  logic [CNT_W-1:0]   r_add_cnt;
  logic [CNT_W-1:0]   r_mul_cnt;

  // A slot draining this cycle can be refilled on the same edge.
  assign w_slot_free = ~r_rsp_valid | rsp_ready;

  always_comb begin
    w_elig_add = '0;
    w_elig_mul = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_elig_add[k] = rst_n & req_valid[k] & w_slot_free[k] & (req_op[k] == OP_ADD);
      w_elig_mul[k] = rst_n & req_valid[k] & w_slot_free[k] & (req_op[k] == OP_MUL);
    end
  end

  rr_arb2 u_arb_add (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_elig_add),
    .gnt   (w_gnt_add)
  );

  rr_arb2 u_arb_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_elig_mul),
    .gnt   (w_gnt_mul)
  );

  assign w_gnt     = w_gnt_add | w_gnt_mul;
  assign req_ready = w_gnt;
  assign fpu_inst  = FPU_INST;

  always_comb begin
    fpu_rs1 = '0;
    fpu_rs2 = '0;
    fpu_rs3 = '0;
    fpu_rs4 = '0;
    if (w_gnt_add[0]) begin
      fpu_rs1 = req_a[0 +: W];
      fpu_rs2 = req_b[0 +: W];
    end else if (w_gnt_add[1]) begin
      fpu_rs1 = req_a[W +: W];
      fpu_rs2 = req_b[W +: W];
    end
    if (w_gnt_mul[0]) begin
      fpu_rs3 = req_a[0 +: W];
      fpu_rs4 = req_b[0 +: W];
    end else if (w_gnt_mul[1]) begin
      fpu_rs3 = req_a[W +: W];
      fpu_rs4 = req_b[W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_op    <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_rsp_data[k] <= '0;
        r_rsp_tag[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_gnt[k]) begin
          r_rsp_data[k]  <= w_gnt_add[k] ? fpu_rd1 : fpu_rd2;
          r_rsp_tag[k]   <= req_tag[k*TAG_W +: TAG_W];
          r_rsp_op[k]    <= req_op[k];
          r_rsp_valid[k] <= 1'b1;
        end else if (rsp_ready[k] && r_rsp_valid[k]) begin
          r_rsp_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_add_cnt <= '0;
      r_mul_cnt <= '0;
    end else begin
      if ((|w_gnt_add) && (r_add_cnt != C_CNT_MAX)) r_add_cnt <= r_add_cnt + C_CNT_ONE;
      if ((|w_gnt_mul) && (r_mul_cnt != C_CNT_MAX)) r_mul_cnt <= r_mul_cnt + C_CNT_ONE;
    end
  end

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
      assign rsp_data[k*W +: W]         = r_rsp_data[k];
      assign rsp_tag[k*TAG_W +: TAG_W]  = r_rsp_tag[k];
    end
  endgenerate

  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign add_cnt   = r_add_cnt;
  assign mul_cnt   = r_mul_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fpu_op_scheduler                                                |
// | Brief  : Directed bench for fpu_op_scheduler with a stub bfloat16 FPU.      |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_fpu_op_scheduler;
  import fpu_sched_pkg::*;

  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_op;
  logic [2*W-1:0]    req_a, req_b;
  logic [2*TAG_W-1:0] req_tag;
  logic [1:0]        rsp_valid, rsp_ready, rsp_op;
  logic [2*W-1:0]    rsp_data;
  logic [2*TAG_W-1:0] rsp_tag;
  logic              fpu_inst;
  logic [W-1:0]      fpu_rs1, fpu_rs2, fpu_rs3, fpu_rs4, fpu_rd1, fpu_rd2;
  logic              cnt_clr;
  logic [CNT_W-1:0]  add_cnt, mul_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Known operand pairs return their true bfloat16 result, anything else an XOR.
  always_comb begin
    fpu_rd1 = (fpu_rs1 == BF16_ONE && fpu_rs2 == BF16_TWO)   ? BF16_THREE : (fpu_rs1 ^ fpu_rs2);
    fpu_rd2 = (fpu_rs3 == BF16_TWO && fpu_rs4 == BF16_THREE) ? BF16_SIX   : (fpu_rs3 ^ fpu_rs4);
  end

  fpu_op_scheduler #(.W(W), .TAG_W(TAG_W), .CNT_W(CNT_W), .FPU_INST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_op(rsp_op),
    .fpu_inst(fpu_inst), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
    .fpu_rs3(fpu_rs3), .fpu_rs4(fpu_rs4), .fpu_rd1(fpu_rd1), .fpu_rd2(fpu_rd2),
    .cnt_clr(cnt_clr), .add_cnt(add_cnt), .mul_cnt(mul_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TAG_W-1:0] t);
    req_op[k]             = op;
    req_a[k*W +: W]       = a;
    req_b[k*W +: W]       = b;
    req_tag[k*TAG_W +: TAG_W] = t;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; req_op = 2'b00; req_a = '0; req_b = '0;
    req_tag = '0; rsp_ready = 2'b00; cnt_clr = 1'b0;

    // Reset
    #1;
    check("ready_in_reset", {30'd0, req_ready}, 32'd0);
    tick();
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_add_cnt", {28'd0, add_cnt}, 32'd0);
    check("rst_mul_cnt", {28'd0, mul_cnt}, 32'd0);
    check("fpu_inst", {31'd0, fpu_inst}, 32'd1);

    // Single add from requester 0
    rst_n = 1'b1;
    req_valid = 2'b01;
    set_req(0, OP_ADD, BF16_ONE, BF16_TWO, 4'd3);
    #1;
    check("add_ready", {30'd0, req_ready}, 32'b01);
    check("add_rs1", {16'd0, fpu_rs1}, {16'd0, BF16_ONE});
    check("add_rs2", {16'd0, fpu_rs2}, {16'd0, BF16_TWO});
    check("add_rs3_idle", {16'd0, fpu_rs3}, 32'd0);
    tick();
    req_valid = 2'b00;
    check("add_rsp_valid", {30'd0, rsp_valid}, 32'b01);
    check("add_rsp_data", {16'd0, rsp_data[15:0]}, {16'd0, BF16_THREE});
    check("add_rsp_tag", {28'd0, rsp_tag[3:0]}, 32'd3);
    check("add_rsp_op", {31'd0, rsp_op[0]}, 32'd0);
    check("add_cnt_1", {28'd0, add_cnt}, 32'd1);

    // Parallel add (req0) and mult (req1); slot 0 drains and refills
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    set_req(0, OP_ADD, BF16_ONE, BF16_TWO, 4'd5);
    set_req(1, OP_MUL, BF16_TWO, BF16_THREE, 4'd9);
    #1;
    check("par_ready", {30'd0, req_ready}, 32'b11);
    check("par_rs3", {16'd0, fpu_rs3}, {16'd0, BF16_TWO});
    check("par_rs4", {16'd0, fpu_rs4}, {16'd0, BF16_THREE});
    tick();
    req_valid = 2'b00;
    check("par_rsp_valid", {30'd0, rsp_valid}, 32'b11);
    check("par_rsp0", {16'd0, rsp_data[15:0]}, {16'd0, BF16_THREE});
    check("par_rsp1", {16'd0, rsp_data[31:16]}, {16'd0, BF16_SIX});
    check("par_tag0", {28'd0, rsp_tag[3:0]}, 32'd5);
    check("par_tag1", {28'd0, rsp_tag[7:4]}, 32'd9);
    check("par_op1", {31'd0, rsp_op[1]}, 32'd1);
    check("par_add_cnt", {28'd0, add_cnt}, 32'd2);
    check("par_mul_cnt", {28'd0, mul_cnt}, 32'd1);
    tick();
    check("drain_valid", {30'd0, rsp_valid}, 32'd0);

    // Back-pressure on requester 0
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    set_req(0, OP_ADD, BF16_ONE, BF16_TWO, 4'd1);
    set_req(1, OP_ADD, 16'h00F0, 16'h000F, 4'd2);
    #1;
    check("bp_first", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_blocked_ready", {30'd0, req_ready}, 32'b10);
      tick();
      check("bp_hold_valid0", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp_hold_data0", {16'd0, rsp_data[15:0]}, {16'd0, BF16_THREE});
      check("bp_req1_data", {16'd0, rsp_data[31:16]}, 32'h00FF);
    end
    rsp_ready = 2'b11;
    set_req(0, OP_ADD, 16'h1234, 16'h0F0F, 4'd7);
    #1;
    check("bp_release_ready", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = 2'b00;
    check("bp_new_data0", {16'd0, rsp_data[15:0]}, 32'h1D3B);
    check("bp_new_tag0", {28'd0, rsp_tag[3:0]}, 32'd7);
    check("bp_add_cnt", {28'd0, add_cnt}, 32'd6);
    tick();

    // Reset while an add is requested; add pointer currently favours requester 1
    req_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {30'd0, req_ready}, 32'd0);
    tick();
    check("rst_mid_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_mid_add_cnt", {28'd0, add_cnt}, 32'd0);
    check("rst_mid_mul_cnt", {28'd0, mul_cnt}, 32'd0);
    rst_n = 1'b1;

    // Contention: both add every cycle, alternating from requester 0
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'b01 : 32'b10);
      tick();
    end
    check("rr_add_cnt", {28'd0, add_cnt}, 32'd4);

    // Saturation after 20 grants, then clear with a concurrent grant
    repeat (16) tick();
    check("sat_add_cnt", {28'd0, add_cnt}, 32'd15);
    cnt_clr = 1'b1;
    #1;
    check("clr_grant_ready", {31'd0, |req_ready}, 32'd1);
    tick();
    cnt_clr = 1'b0;
    check("clr_add_cnt", {28'd0, add_cnt}, 32'd0);
    tick();
    check("post_clr_add_cnt", {28'd0, add_cnt}, 32'd1);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
